// File: rtl/alu_cmd_sequencer.sv
// UART command sequencer for the registered 4-bit ALU: opcode byte + operand byte in, result byte out.
// Define ALU_SEQ_CHECKSUM_EN to follow each result with an XOR checksum byte.
module alu_cmd_sequencer #(
  parameter logic [3:0] HEADER         = 4'hA,
  parameter int         ALU_LATENCY    = 1,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] ERR_CODE       = 8'hEE
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [3:0] alu_op,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  input  logic [7:0] alu_result,
  output logic       busy,
  output logic       err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] LAT = 4'(ALU_LATENCY);
  localparam logic [3:0] OP_DIV = 4'hE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_OPND,
    S_EXEC,
`ifdef ALU_SEQ_CHECKSUM_EN
    S_SEND,
    S_SEND_CK
`else
    S_SEND
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [3:0]    a_q, a_d;
  logic [3:0]    b_q, b_d;
  logic [7:0]    result_q, result_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    ex_cnt_q, ex_cnt_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    to_cnt_d   = to_cnt_q;
    ex_cnt_d   = ex_cnt_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data[7:4] == HEADER) begin
            op_d     = rx_data[3:0];
            to_cnt_d = '0;
            state_d  = S_GET_OPND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_GET_OPND: begin
        if (rx_valid) begin
          a_d = rx_data[7:4];
          b_d = rx_data[3:0];
          // divide by zero is answered here; the ALU never sees it
          if (op_q == OP_DIV && rx_data[3:0] == 4'h0) begin
            result_d   = ERR_CODE;
            tx_data_d  = ERR_CODE;
            tx_valid_d = 1'b1;
            err_d      = 1'b1;
            state_d    = S_SEND;
          end else begin
            ex_cnt_d = '0;
            state_d  = S_EXEC;
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      S_EXEC: begin
        err_d = rx_valid;
        if (ex_cnt_q == LAT) begin
          result_d   = alu_result;
          tx_data_d  = alu_result;
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end else begin
          ex_cnt_d = ex_cnt_q + 4'd1;
        end
      end
      S_SEND: begin
        err_d = rx_valid;
        if (tx_ready) begin
`ifdef ALU_SEQ_CHECKSUM_EN
          tx_data_d = {HEADER, op_q} ^ {a_q, b_q}
                    ^ result_q;
          state_d   = S_SEND_CK;
`else
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
`endif
        end
      end
`ifdef ALU_SEQ_CHECKSUM_EN
      S_SEND_CK: begin
        err_d = rx_valid;
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
`endif
      default: begin
        tx_valid_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
    alu_op_d = (state_d == S_EXEC) ? op_d : 4'h0;
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      to_cnt_q   <= '0;
      ex_cnt_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      alu_op_q   <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      to_cnt_q   <= to_cnt_d;
      ex_cnt_q   <= ex_cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      alu_op_q   <= alu_op_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign alu_op   = alu_op_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer with a registered reference ALU.
// Build with ALU_SEQ_CHECKSUM_EN defined to also expect checksum bytes.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [3:0] alu_op, alu_a, alu_b;
  logic [7:0] alu_result = 8'h00;
  logic       busy, err;

  int n_cmp = 0;
  int n_bad = 0;
  int err_cnt = 0;
  bit saw_op_e = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.TIMEOUT_CYCLES(20)) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .busy(busy), .err(err)
  );

  function automatic logic [7:0] alu_f(
    input logic [3:0] op, a, b);
    logic [7:0] ea, eb;
    ea = {4'h0, a};
    eb = {4'h0, b};
    case (op)
      4'h1: return ea + eb;
      4'h2: return ea - eb;
      4'h3: return ea & eb;
      4'h4: return ea | eb;
      4'h5: return ea ^ eb;
      4'h6: return ea * eb;
      4'hE: return (b == 4'h0) ? 8'h00 : ea / eb;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk)
    alu_result <= alu_f(alu_op, alu_a, alu_b);

  task automatic check(input string name,
                       input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // monitor: samples just after the falling edge
  always @(negedge clk) begin
    #1;
    if (err === 1'b1) err_cnt++;
    if (alu_op === 4'hE) saw_op_e = 1'b1;
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_tx", tx_data, 8'hxx);
      end else begin
        check("tx_byte", tx_data, exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [7:0] res,
                      input logic [7:0] ck);
    exp_q.push_back(res);
`ifdef ALU_SEQ_CHECKSUM_EN
    exp_q.push_back(ck);
`else
    if (ck === 8'hxx) exp_q.push_back(ck);
`endif
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy !== 1'b0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check(name, 8'(busy), 8'h00);
  endtask

  task automatic check_zero(input string name);
    check({name, "_tx_valid"}, 8'(tx_valid), 8'h00);
    check({name, "_tx_data"}, tx_data, 8'h00);
    check({name, "_alu_op"}, 8'(alu_op), 8'h00);
    check({name, "_alu_a"}, 8'(alu_a), 8'h00);
    check({name, "_alu_b"}, 8'(alu_b), 8'h00);
    check({name, "_busy"}, 8'(busy), 8'h00);
    check({name, "_err"}, 8'(err), 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int unstable;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b0;

    // A1 23: add 2+3, latency check
    tx_ready = 1'b1;
    e0 = err_cnt;
    push(8'h05, 8'h87);
    send(8'hA1);
    send(8'h23);
    check("exec_op", 8'(alu_op), 8'h01);
    check("exec_a", 8'(alu_a), 8'h02);
    check("exec_b", 8'(alu_b), 8'h03);
    @(negedge clk);
    check("lat_early", 8'(tx_valid), 8'h00);
    @(negedge clk);
    check("lat_valid", 8'(tx_valid), 8'h01);
    check("lat_data", tx_data, 8'h05);
    wait_idle("add_idle");
    check("add_err", 8'(err_cnt - e0), 8'h00);

    // AE 40: divide by zero rejected
    e0 = err_cnt;
    push(8'hEE, 8'h00);
    send(8'hAE);
    send(8'h40);
    wait_idle("div0_idle");
    check("div0_err", 8'(err_cnt - e0), 8'h01);
    check("div0_no_op_e", 8'(saw_op_e), 8'h00);

    // bad header, then A6 34: 3*4
    e0 = err_cnt;
    send(8'h51);
    check("hdr_err_pulse", 8'(err), 8'h01);
    check("hdr_busy", 8'(busy), 8'h00);
    push(8'h0C, 8'h9E);
    send(8'hA6);
    send(8'h34);
    wait_idle("mul_idle");
    check("hdr_err", 8'(err_cnt - e0), 8'h01);

    // timeout, then A2 53: 5-3
    e0 = err_cnt;
    send(8'hA1);
    repeat (25) @(negedge clk);
    check("to_busy", 8'(busy), 8'h00);
    check("to_err", 8'(err_cnt - e0), 8'h01);
    push(8'h02, 8'hF3);
    send(8'hA2);
    send(8'h53);
    wait_idle("sub_idle");

    // A3 6C with receiver stalled
    tx_ready = 1'b0;
    e0 = err_cnt;
    push(8'h04, 8'hCB);
    send(8'hA3);
    send(8'h6C);
    @(negedge clk);
    @(negedge clk);
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      rx_data  = 8'h77;
      rx_valid = (i == 4);
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== 8'h04)
        unstable++;
    end
    rx_valid = 1'b0;
    check("stall_stable", 8'(unstable), 8'h00);
    check("stall_err", 8'(err_cnt - e0), 8'h01);
    tx_ready = 1'b1;
    @(negedge clk);
`ifdef ALU_SEQ_CHECKSUM_EN
    @(negedge clk);
`endif
    check("stall_busy", 8'(busy), 8'h00);
    check("stall_txv", 8'(tx_valid), 8'h00);

    // reset during EXEC of A4 12
    send(8'hA4);
    send(8'h12);
    check("mid_busy", 8'(busy), 8'h01);
    reset_n = 1'b1;
    #1;
    check_zero("midreset");
    @(negedge clk);
    reset_n = 1'b0;
    push(8'h03, 8'hB5);
    send(8'hA4);
    send(8'h12);
    wait_idle("or_idle");

    repeat (3) @(negedge clk);
    check("sb_empty", 8'(exp_q.size()), 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command controller that sits between the UART byte receiver/transmitter and the registered 4-bit ALU.
- Assembles a two-byte command from the UART RX stream and drives opcode/operands to the ALU.
- Waits the ALU's register latency, captures the 8-bit result and returns it as a TX byte with a valid/ready handshake.
- Also rejects malformed commands, divide-by-zero and stalled commands.

Parameters:
- HEADER, 4'hA, required upper nibble of the opcode byte.
- ALU_LATENCY, 1, clock cycles from stable ALU inputs to a valid ALU result (1..15).
- TIMEOUT_CYCLES, 1000, max idle cycles between opcode byte and operand byte.
- ERR_CODE, 8'hEE, byte transmitted for a rejected command.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous reset, active-high (reset asserted when 1)
- rx_data  in  8  received UART byte
- rx_valid  in  1  one-cycle strobe, rx_data valid
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid, held until accepted
- tx_ready  in  1  transmitter accepts tx_data when high with tx_valid
- alu_op  out  4  ALU operation select
- alu_a  out  4  ALU operand a
- alu_b  out  4  ALU operand b
- alu_result  in  8  registered ALU result
- busy  out  1  high in any state other than IDLE
- err  out  1  one-cycle pulse on any rejected command or dropped byte

Behaviour:
- Reset values: all outputs 0; state IDLE; internal opcode/operand/result/counters cleared. Reset is honoured in any state, including mid-EXEC or mid-SEND; tx_valid drops immediately.
- alu_op is 4'h0 (ALU default, result 0) in every state except EXEC.
- alu_a and alu_b hold their last captured values.

State machine:
- IDLE:
  - On rx_valid with rx_data[7:4]==HEADER: latch op = rx_data[3:0], go to GET_OPND, clear the timeout counter.
  - On a bad header: pulse err, stay in IDLE.
- GET_OPND:
  - On rx_valid: latch a = rx_data[7:4], b = rx_data[3:0].
  - If op==4'hE and b==0: load result = ERR_CODE, pulse err, go to SEND. The ALU never sees the divide.
  - Otherwise go to EXEC.
  - With no rx_valid: increment the counter. When it reaches TIMEOUT_CYCLES-1, pulse err and go to IDLE.
- EXEC:
  - Drive alu_op = op, alu_a/alu_b = latched operands, held stable for ALU_LATENCY+1 cycles.
  - On the last of those cycles, capture alu_result into the result register, then go to SEND.
  - Total latency from the operand-byte rx_valid to tx_valid = ALU_LATENCY+2 cycles (3 at default).
- SEND:
  - tx_valid=1 and tx_data=result, both stable until tx_ready.
  - On the cycle where tx_valid and tx_ready are both high, the transfer occurs: go to IDLE, tx_valid=0 next cycle.
  - tx_ready high before tx_valid has no effect.
- rx_valid in EXEC or SEND: byte dropped, err pulsed, state unchanged.
- Opcodes are not range-checked; undefined opcodes return whatever the ALU produces (0).
- The result is passed through unmodified, e.g. the zero-extended subtraction 2-3 returns 8'hFF.
- Timeout counter width is $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- Macro: ALU_SEQ_CHECKSUM_EN.
- When defined: after the result byte is accepted, the FSM enters SEND_CK and transmits a second byte = opcode_byte XOR operand_byte XOR result, with the same handshake, then goes to IDLE.
  - For rejected divide-by-zero, the checksum covers ERR_CODE.
  - If the command timed out, nothing is sent.
- When undefined: a single byte is sent and the SEND_CK state does not exist.

Test Plan:
- Send 8'hA1, then 8'h23, tx_ready=1: alu_op=1, a=2, b=3 during EXEC; tx_data=8'h05 with tx_valid 3 cycles after the second rx_valid. With checksum enabled, the next byte is 8'h87.
- Send 8'hAE, then 8'h40: alu_op never equals 4'hE; err pulses; tx_data=8'hEE.
- Send 8'h51: err pulses; busy stays 0. Follow with 8'hA6, 8'h34: tx_data=8'h0C.
- Send 8'hA1, then no byte for TIMEOUT_CYCLES (use TIMEOUT_CYCLES=20): err pulses, busy=0. Then 8'hA2, 8'h53 gives tx_data=8'h02.
- Send 8'hA3, 8'h6C with tx_ready=0 for 10 cycles: tx_valid and tx_data=8'h04 held stable throughout. An extra rx byte in this window pulses err and does not change tx_data. Raising tx_ready completes the transfer, and busy falls next cycle.
- Assert reset_n during EXEC of 8'hA4, 8'h12: all outputs 0 immediately and the FSM is in IDLE. A fresh command then works normally.
